// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors and the receiver FSM state encoding,
// common to uart_rx_stdin and uart_tx.
package uart_pkg;

  // 12 MHz board clock divided down to 115200 baud.
  localparam int B115200 = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: dout always reflects the head entry, and reads 0 while empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal assigned here gets its default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy count and the empty-gated dout hide stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_stdin.sv
// 8N1 UART receiver that queues bytes for the CPU's stdin behind a valid/ready handshake,
// flagging framing errors (one pulse per bad frame) and a sticky FIFO overrun.
module uart_rx_stdin
  import uart_pkg::*;
#(
  parameter int BAUD       = B115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] stdin_data,
  output logic       stdin_valid,
  input  logic       stdin_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD/2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD - 1);

  logic          rx_meta_q, rx_s_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          tick, push, pop, fifo_empty, fifo_full;

  assign tick        = (cnt_q == '0);
  assign stdin_valid = !fifo_empty;
  assign pop         = stdin_valid && stdin_ready;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign overrun_d   = overrun_q | (push & fifo_full & ~pop);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_BIT;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = FULL_BIT;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = FULL_BIT;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        // Stay here until the line returns high so a held-low line reports only once.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (shreg_q),
    .pop  (pop),
    .dout (stdin_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_stdin.sv
// Self-checking bench for uart_rx_stdin (BAUD=16, FIFO_DEPTH=4): directed frames, a scoreboard
// queue of expected bytes, and a monitor that compares every handshake against it.
module tb_uart_rx_stdin;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] stdin_data;
  logic       stdin_valid;
  logic       stdin_ready;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int ferr_count = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_stdin #(
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .stdin_data (stdin_data),
    .stdin_valid(stdin_valid),
    .stdin_ready(stdin_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change on the falling edge, so sample 1 time unit later, well before the next rise.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (frame_err) ferr_count++;
      if (stdin_valid && stdin_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no byte", stdin_data);
        end else begin
          check("pop_data", {24'h0, stdin_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // Drives one 10-bit frame starting on a falling edge; expected bytes enter the scoreboard first.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_it);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    if (expect_it) exp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BAUD) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    stdin_ready = 1'b1;
    idle(3 * DEPTH);
    stdin_ready = 1'b0;
    check({name, "_scoreboard_left"}, exp_q.size(), 0);
    check({name, "_valid_after_drain"}, {31'h0, stdin_valid}, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int f0;
    logic [7:0] part;

    reset       = 1'b1;
    rx          = 1'b1;
    stdin_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    check("reset_valid",     {31'h0, stdin_valid}, 0);
    check("reset_data",      {24'h0, stdin_data},  0);
    check("reset_frame_err", {31'h0, frame_err},   0);
    check("reset_overrun",   {31'h0, overrun},     0);
    idle(4);

    // 1: stop sample lands 2 sync + 1 detect + BAUD/2 + 9*BAUD = 155 cycles after the start edge.
    first = -1;
    fork
      send_frame(8'h41, 1'b1, 1'b1);
      begin
        for (int k = 1; k <= 158; k++) begin
          @(negedge clk);
          if (stdin_valid && first < 0) first = k;
        end
      end
    join
    check("t1_valid_latency", first, 155);
    check("t1_head_data", {24'h0, stdin_data}, 32'h41);
    drain("t1");

    // 2: three back-to-back frames held in the FIFO
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1);
    check("t2_valid", {31'h0, stdin_valid}, 1);
    check("t2_head_data", {24'h0, stdin_data}, 32'h00);
    drain("t2");
    check("t2_no_frame_err", ferr_count, 0);

    // 3: short low glitch is rejected at the start-bit mid-point
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * BAUD);
    check("t3_no_push", {31'h0, stdin_valid}, 0);
    check("t3_no_frame_err", ferr_count, 0);

    // 4: bad stop bit, then line held low for 3 bit times
    f0 = ferr_count;
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    idle(3 * BAUD);
    rx = 1'b1;
    idle(2 * BAUD);
    check("t4_one_frame_err", ferr_count, f0 + 1);
    check("t4_fifo_unchanged", {31'h0, stdin_valid}, 0);
    send_frame(8'h33, 1'b1, 1'b1);
    drain("t4");

    // 5a: five bytes, no pops; the fifth is dropped and overrun sticks
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, i <= DEPTH);
    check("t5_overrun_set", {31'h0, overrun}, 1);
    idle(2 * BAUD);
    check("t5_overrun_sticky", {31'h0, overrun}, 1);
    drain("t5a");
    check("t5_overrun_after_pops", {31'h0, overrun}, 1);
    pulse_reset();
    check("t5_overrun_cleared", {31'h0, overrun}, 0);
    idle(4);

    // 5b: fifth stop sample coincides with a pop of the head entry
    for (int i = 0; i < DEPTH; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b1);
    fork
      send_frame(8'h15, 1'b1, 1'b1);
      begin
        idle(154);
        stdin_ready = 1'b1;
        @(negedge clk);
        stdin_ready = 1'b0;
      end
    join
    check("t5b_no_overrun", {31'h0, overrun}, 0);
    check("t5b_head_data", {24'h0, stdin_data}, 32'h12);
    drain("t5b");

    // 6: reset during bit 3 of a frame with two bytes queued
    send_frame(8'hC3, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("t6_queued", {31'h0, stdin_valid}, 1);
    part = 8'hAA;
    rx = 1'b0;
    idle(BAUD);
    for (int i = 0; i < 3; i++) begin
      rx = part[i];
      idle(BAUD);
    end
    rx = part[3];
    idle(BAUD / 2);
    pulse_reset();
    check("t6_valid_cleared", {31'h0, stdin_valid}, 0);
    check("t6_overrun_clear", {31'h0, overrun}, 0);
    idle(BAUD);
    send_frame(8'h7E, 1'b1, 1'b1);
    check("t6_head_data", {24'h0, stdin_data}, 32'h7E);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
